exe_muldiv_seq: RTL
===================

# exe_muldiv_seq

Multi-cycle multiply/divide sequencer in the EXE stage. It accepts one MULT/MULTU/DIV/DIVU request from the ID/EXE register and runs a radix-2 iterative shift-add or shift-subtract over WIDTH cycles. It holds the pipeline stalled while running, then presents a 64-bit HI/LO result with a one-cycle write enable toward the EXE/MEM register and the hilo file. The ALU keeps single-cycle ops; this block owns every op that writes HI/LO from an arithmetic result.

## Interface

Parameters:
- WIDTH, 32: operand width; equals WIDTH_REG.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request valid; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src1  in  WIDTH  multiplicand or dividend.
- src2  in  WIDTH  multiplier or divisor.
- flush  in  1  abort the current operation; has priority over everything except rst.
- stall_req  out  1  pipeline stall request to hazard control.
- busy  out  1  high in MUL, DIV and DONE.
- done  out  1  one-cycle result strobe.
- hilowe  out  1  HI/LO write enable; equals done.
- hi  out  WIDTH  product high word or remainder.
- lo  out  WIDTH  product low word or quotient.

## Operation

FSM states: IDLE, MUL, DIV, DONE.

- IDLE, start=1, flush=0:
  - Latch op, the sign flags and the operand magnitudes. Signed ops take two's-complement absolute values; unsigned ops take the raw operands.
  - Clear cnt and the 2·WIDTH accumulator.
  - Go to MUL for op[1]=0, otherwise DIV.
- DIV with src2==0 at start: go straight to DONE with hi=src1 and lo={WIDTH{1}}.
- MUL, one iteration per cycle:
  - If multiplier bit 0 is set, add the multiplicand to acc[2W-1:W].
  - Shift acc and the multiplier right one place.
- DIV, one iteration per cycle (restoring):
  - Shift the remainder:quotient pair left one place.
  - If rem ≥ divisor, subtract the divisor and set the quotient LSB.
- MUL/DIV exit: cnt increments each iteration. After the iteration with cnt==WIDTH-1, go to DONE.
- DONE, sign correction:
  - Product is negated when the operand signs differ (signed ops only).
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
  - INT_MIN/−1 gives lo=0x80000000, hi=0 (natural wrap).
- DONE outputs: done=hilowe=1 and hi/lo valid for that cycle only. Next state is IDLE unconditionally.
- hi/lo hold their value after DONE until the next DONE. They are 0 after reset.
- stall_req = (IDLE & start & ~flush) | MUL | DIV. It is combinational, so the requesting instruction stalls in the same cycle. It is low in DONE, which lets the instruction advance with the result.
- start outside IDLE is ignored.
- flush in any state: next state IDLE, no done/hilowe. The accumulator is discarded and hi/lo are not updated.
- flush and start together in IDLE: flush wins and nothing is latched.
- rst: state IDLE. stall_req, busy, done, hilowe, hi and lo are all 0.

## Timing

- start accepted at cycle 0; iterations run in cycles 1..WIDTH; done at cycle WIDTH+1, which is 33 for WIDTH=32.
- Divide-by-zero: done at cycle 1.
- Back-to-back: a new start is accepted in the IDLE cycle right after DONE. Minimum issue interval is WIDTH+2 cycles.
- Flush at cycle k: busy=0 at k+1, and a start at k+1 is accepted.
- hi/lo/done/hilowe are registered. Only stall_req has a combinational path from start/flush.

## Configuration

- DIV_EN defined: full divider with the DIV state.
- DIV_EN undefined: the divide path and DIV state are not compiled. A DIV/DIVU start does not stall. The FSM goes IDLE→DONE and asserts done with hilowe=0, hi/lo unchanged. MULT/MULTU are unaffected.

## Test plan

- MULT src1=0xFFFFFFFD (−3), src2=7 -> done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, hilowe=1 for one cycle, stall_req high cycles 0–32.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> lo=14, hi=2. DIV −7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 5/0 -> done at cycle 1, hi=5, lo=0xFFFFFFFF. Without DIV_EN: done at cycle 1, hilowe=0, no stall.
- MULT started, flush at cycle 10 -> no done, busy=0 at cycle 11. MULTU 3×4 started at cycle 11 -> done at cycle 44, lo=12, hi=0. A start pulse at cycle 5 is ignored.
- rst asserted mid-DIV -> next cycle all outputs 0 and state IDLE. The first post-reset op gives a correct result.

Source files
------------

// File: rtl/exe_muldiv_seq.sv
`timescale 1ns/1ps
// exe_muldiv_seq
// ---------------------------------------------------------------------------
// Multi-cycle multiply/divide sequencer for the EXE stage. One MULT, MULTU,
// DIV or DIVU request is accepted in IDLE. The block then runs a radix-2
// iterative shift-add (multiply) or restoring shift-subtract (divide) for
// WIDTH cycles while holding the pipeline stalled. Finally it presents a
// registered HI/LO result together with a one-cycle done/hilowe strobe.
//
// Build option:
//   DIV_EN  defined   : full divider, DIV state present.
//           undefined : no divide datapath. A DIV/DIVU start does not stall;
//                       it goes IDLE->DONE with done=1, hilowe=0 and leaves
//                       hi/lo unchanged.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   start       request valid, sampled only in IDLE
//   op          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1        multiplicand / dividend
//   src2        multiplier / divisor
//   flush       abort, wins over everything except rst
//   stall_req   stall request to hazard control (combinational)
//   busy        high in MUL, DIV and DONE
//   done        one-cycle result strobe
//   hilowe      HI/LO write enable
//   hi, lo      product high/low word, or remainder/quotient
//   dbg_state_o current FSM state encoding (0 IDLE, 1 MUL, 2 DIV, 3 DONE)
//
// Handshake: a request is taken on a rising edge where the FSM is IDLE,
// start=1 and flush=0. There is no backpressure on the result; hi/lo are
// valid only in the cycle where done=1 and keep their value afterwards.
// ---------------------------------------------------------------------------
module exe_muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             flush,
   output logic             stall_req,
   output logic             busy,
   output logic             done,
   output logic             hilowe,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       dbg_state_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
`ifdef DIV_EN
      ST_DIV  = 2'd2,
`endif
      ST_DONE = 2'd3
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   // acc_q: {upper half, lower half}.
   //   MUL: upper = running partial product, lower = multiplier being
   //        consumed from bit 0 while product bits shift in from the top.
   //   DIV: upper = partial remainder, lower = dividend being consumed from
   //        the MSB while quotient bits shift in at bit 0.
   logic [2*WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]     opb_q;     // multiplicand magnitude or divisor magnitude
   logic                 sign1_q;   // src1 was negative (signed ops only)
   logic                 sign2_q;   // src2 was negative (signed ops only)
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;
   logic                 done_q;
   logic                 hilowe_q;

   // Operand magnitudes; unsigned ops pass the raw operands through.
   logic                 is_signed;
   logic                 neg1;
   logic                 neg2;
   logic [WIDTH-1:0]     mag1;
   logic [WIDTH-1:0]     mag2;

   assign is_signed = ~op[0];
   assign neg1      = is_signed & src1[WIDTH-1];
   assign neg2      = is_signed & src2[WIDTH-1];
   assign mag1      = neg1 ? -src1 : src1;
   assign mag2      = neg2 ? -src2 : src2;

   // Multiply iteration: conditional add into the upper half, then shift the
   // whole accumulator right. The add carry becomes the new MSB.
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_acc;
   logic [2*WIDTH-1:0]   prod_res;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
   assign mul_acc  = {mul_sum, acc_q[WIDTH-1:1]};
   assign prod_res = (sign1_q ^ sign2_q) ? -mul_acc : mul_acc;

`ifdef DIV_EN
   // Restoring divide iteration. The shifted remainder needs one extra bit
   // for the compare; when the subtract happens the true difference is below
   // 2^WIDTH, so a WIDTH-bit subtract is exact.
   logic [WIDTH:0]       rem_sh;
   logic                 div_ge;
   logic [WIDTH-1:0]     rem_nxt;
   logic [2*WIDTH-1:0]   div_acc;
   logic [WIDTH-1:0]     quo_res;
   logic [WIDTH-1:0]     rem_res;

   assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_ge  = (rem_sh >= {1'b0, opb_q});
   assign rem_nxt = div_ge ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];
   assign div_acc = {rem_nxt, acc_q[WIDTH-2:0], div_ge};
   // Quotient negated when signs differ; remainder follows the dividend.
   // INT_MIN / -1 wraps naturally to INT_MIN with remainder 0.
   assign quo_res = (sign1_q ^ sign2_q) ? -div_acc[WIDTH-1:0] : div_acc[WIDTH-1:0];
   assign rem_res = sign1_q ? -div_acc[2*WIDTH-1:WIDTH] : div_acc[2*WIDTH-1:WIDTH];
`endif

   // Combinational stall: the requesting instruction must stall in the same
   // cycle it presents start. DONE does not stall so the instruction can
   // advance with the result.
   logic start_stall;
   logic iterating;

`ifdef DIV_EN
   assign start_stall = start & ~flush;
   assign iterating   = (state_q == ST_MUL) | (state_q == ST_DIV);
`else
   assign start_stall = start & ~flush & ~op[1];
   assign iterating   = (state_q == ST_MUL);
`endif

   assign stall_req   = ~rst & (((state_q == ST_IDLE) & start_stall) | iterating);
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign hilowe      = hilowe_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign dbg_state_o = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         sign1_q  <= 1'b0;
         sign2_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         hilowe_q <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-armed below.
         done_q   <= 1'b0;
         hilowe_q <= 1'b0;
         if (flush) begin
            // Abandon any work in flight; hi/lo keep their last result.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     cnt_q   <= '0;
                     sign1_q <= neg1;
                     sign2_q <= neg2;
                     if (!op[1]) begin
                        acc_q   <= {{WIDTH{1'b0}}, mag2};
                        opb_q   <= mag1;
                        state_q <= ST_MUL;
                     end else begin
`ifdef DIV_EN
                        if (src2 == '0) begin
                           // Divide by zero finishes immediately.
                           acc_q    <= '0;
                           hi_q     <= src1;
                           lo_q     <= '1;
                           done_q   <= 1'b1;
                           hilowe_q <= 1'b1;
                           state_q  <= ST_DONE;
                        end else begin
                           acc_q   <= {{WIDTH{1'b0}}, mag1};
                           opb_q   <= mag2;
                           state_q <= ST_DIV;
                        end
`else
                        // No divider: acknowledge with done but write nothing.
                        acc_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
`endif
                     end
                  end
               end

               ST_MUL: begin
                  acc_q <= mul_acc;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_LAST) begin
                     // Sign-correct the final product on the way into DONE so
                     // hi/lo are registered and valid in the DONE cycle.
                     hi_q     <= prod_res[2*WIDTH-1:WIDTH];
                     lo_q     <= prod_res[WIDTH-1:0];
                     done_q   <= 1'b1;
                     hilowe_q <= 1'b1;
                     state_q  <= ST_DONE;
                  end
               end

`ifdef DIV_EN
               ST_DIV: begin
                  acc_q <= div_acc;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_LAST) begin
                     hi_q     <= rem_res;
                     lo_q     <= quo_res;
                     done_q   <= 1'b1;
                     hilowe_q <= 1'b1;
                     state_q  <= ST_DONE;
                  end
               end
`endif

               ST_DONE: begin
                  state_q <= ST_IDLE;
               end

               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
